// File: rtl/phase_accumulator.sv
// Phase accumulator (NCO core): registered phase += step each cycle, with a registered wrap pulse.
// Optional macro PHASE_STEP_REG_EN inserts a one-cycle step register in front of the adder.
module phase_accumulator #(
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] phase_step,
    output logic [WIDTH-1:0] phase,
    output logic             wrap
);

    logic [WIDTH-1:0] step_eff;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   sum;

`ifdef PHASE_STEP_REG_EN
    logic [WIDTH-1:0] step_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            step_q <= '0;
        end else begin
            step_q <= phase_step;
        end
    end

    assign step_eff = step_q;
`else
    assign step_eff = phase_step;
`endif

    // Extra MSB of the sum is the carry out that becomes the wrap pulse.
    always_comb begin
        sum     = {1'b0, phase_q} + {1'b0, step_eff};
        phase_d = sum[WIDTH-1:0];
        wrap_d  = sum[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
        end
    end

    assign phase = phase_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Scoreboard bench for phase_accumulator: stimulus pushes model predictions, a monitor pops and compares.
module tb_phase_accumulator;

    localparam int unsigned W = 37;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] phase_step = '0;
    logic [W-1:0] phase;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] phase;
        logic         wrap;
        string        tag;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state, plain arithmetic on 64-bit values.
    longint unsigned m_phase = 0;
    longint unsigned m_step_reg = 0;
    longint unsigned modulus = 64'd1 << W;

    phase_accumulator #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .phase_step (phase_step),
        .phase      (phase),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Drive one edge's inputs and predict what the outputs read after that edge.
    task automatic drive(input logic rst, input longint unsigned step, input string tag);
        longint unsigned eff;
        longint unsigned total;
        exp_t e;
        @(negedge clk);
        reset      = rst;
        phase_step = step[W-1:0];
`ifdef PHASE_STEP_REG_EN
        eff = m_step_reg;
`else
        eff = step % modulus;
`endif
        if (!rst) begin
            m_phase    = 0;
            m_step_reg = 0;
            e.wrap     = 1'b0;
        end else begin
            total      = m_phase + eff;
            e.wrap     = (total >= modulus);
            m_phase    = total % modulus;
            m_step_reg = step % modulus;
        end
        e.phase = m_phase[W-1:0];
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle, compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (phase !== e.phase || wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL %s: got phase=%0d wrap=%b, expected phase=%0d wrap=%b",
                             e.tag, phase, wrap, e.phase, e.wrap);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        longint unsigned s;
        // Reset state, then basic accumulation and a step change.
        drive(1'b0, 0, "reset");
        for (int i = 0; i < 4; i++) drive(1'b1, 3200000, "step_3200000");
        for (int i = 0; i < 2; i++) drive(1'b1, 6400000, "step_doubled");
        // Mid-run reset overrides accumulation, then resumes from 0.
        drive(1'b0, 3200000, "mid_reset");
        for (int i = 0; i < 3; i++) drive(1'b1, 3200000, "resume");
        // Half-range step: wraps every second edge.
        drive(1'b0, 0, "reset2");
        for (int i = 0; i < 4; i++) drive(1'b1, 64'd1 << (W - 1), "half_range");
        // Maximum step: wraps on almost every edge.
        drive(1'b0, 0, "reset3");
        for (int i = 0; i < 3; i++) drive(1'b1, modulus - 1, "max_step");
        // Zero step holds phase and keeps wrap low.
        for (int i = 0; i < 3; i++) drive(1'b1, 0, "zero_step");
        // Randomized steps with occasional resets.
        for (int i = 0; i < 300; i++) begin
            s = {32'($urandom), 32'($urandom)} % modulus;
            if ($urandom_range(0, 3) == 0) s = s >> $urandom_range(1, W - 1);
            drive(($urandom_range(0, 19) != 0), s, "random");
        end
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_accumulator.md
PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

Interface
- REQ-001: Parameter WIDTH SHALL default to 37 and set the phase and phase-step width in bits.
- REQ-002: Port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
- REQ-003: Port reset SHALL be an input, 1 bit wide, synchronous and active-low: 0 on a rising clk edge resets the block.
- REQ-004: Port phase_step SHALL be an input, WIDTH bits wide, and carry the unsigned per-cycle phase increment (tuning word).
- REQ-005: Port phase SHALL be an output, WIDTH bits wide, and carry the registered unsigned accumulated phase.
- REQ-006: Port wrap SHALL be an output, 1 bit wide, and be a registered 1-cycle pulse marking phase wrap-around (carry out of the add).

Function
- REQ-007: On each rising clk edge with reset=1, phase SHALL update to (phase + effective_step) mod 2^WIDTH.
- REQ-008: effective_step SHALL be phase_step as sampled on that same edge (zero latency), unless PHASE_STEP_REG_EN is defined (REQ-016).
- REQ-009: The addition SHALL be full-width unsigned with no saturation; carry out of bit WIDTH-1 is discarded from phase.
- REQ-010: wrap SHALL be 1 for exactly the cycle after an edge whose addition produced a carry out of bit WIDTH-1, and 0 otherwise.
- REQ-011: phase_step=0 SHALL hold phase constant and keep wrap at 0.
- REQ-012: A change of phase_step SHALL affect only additions on edges at or after the change; phase is never recomputed retroactively.
- REQ-013: phase and wrap SHALL be driven directly from registers, with no combinational path from phase_step to any output.

Reset
- REQ-014: On a rising clk edge with reset=0, phase SHALL become 0 and wrap SHALL become 0, overriding the accumulation; this includes reset asserted mid-operation.
- REQ-015: On the first edge after reset returns to 1, phase SHALL become 0 + effective_step. Before the first reset, output values are undefined.

Configuration
- REQ-016: When macro PHASE_STEP_REG_EN is defined, phase_step SHALL be captured into an internal WIDTH-bit register each edge (cleared to 0 by reset), and that register SHALL be the effective_step, adding exactly one cycle of step latency.
- REQ-017: When PHASE_STEP_REG_EN is undefined, no step register SHALL exist and REQ-008 zero-latency behaviour SHALL apply.

Verification
- REQ-018: Hold reset=0 for 1 edge, then set reset=1 with phase_step=3200000 -> phase reads 3200000, 6400000, 9600000 after edges 1, 2, 3 (macro undefined).
- REQ-019: Set phase_step=2^36 from reset -> phase reads 2^36, then 0 with wrap=1 for one cycle, then 2^36 with wrap=0.
- REQ-020: Set phase_step=2^37-1 from phase 0 -> phase reads 2^37-1, then 2^37-2 with wrap=1.
- REQ-021: Step 3200000 for 4 edges, then double to 6400000 -> phase reads 12800000, then 19200000, then 25600000.
- REQ-022: Drive reset=0 for one edge mid-run at phase=9600000 -> phase=0 and wrap=0 on that edge; accumulation resumes from 0 on the next edge.
- REQ-023: With PHASE_STEP_REG_EN defined, step 3200000 applied on the first edge after reset -> phase reads 0 after that edge, then 3200000, then 6400000.
